// File: rtl/retry_scheduler_pkg.sv
// retry_scheduler_pkg: entry-state encoding shared by the retry scheduler files.
package retry_scheduler_pkg;
    typedef enum logic [1:0] {FREE, QUEUED, INFLIGHT, RETRY} entry_state_e;

    function automatic logic is_busy(entry_state_e s);
        return s != FREE;
    endfunction
endpackage

// File: rtl/retry_scheduler_if.sv
// retry_scheduler_if: upstream, downstream and completion signals of the retry scheduler.
interface retry_scheduler_if #(
    parameter type DataType = logic [7:0],
    parameter int  IDSize   = 3
);
    DataType           data_i;
    logic              valid_i;
    logic              ready_o;
    DataType           data_o;
    logic [IDSize-1:0] id_o;
    logic              valid_o;
    logic              ready_i;
    logic              done_valid_i;
    logic [IDSize-1:0] done_id_i;
    logic              done_retry_i;
    logic              fail_o;
    logic [IDSize-1:0] fail_id_o;
    logic              spurious_o;
    logic [IDSize:0]   outstanding_o;

    modport master (
        output data_i, valid_i, ready_i, done_valid_i, done_id_i, done_retry_i,
        input  ready_o, data_o, id_o, valid_o, fail_o, fail_id_o, spurious_o, outstanding_o
    );

    modport slave (
        input  data_i, valid_i, ready_i, done_valid_i, done_id_i, done_retry_i,
        output ready_o, data_o, id_o, valid_o, fail_o, fail_id_o, spurious_o, outstanding_o
    );
endinterface

// File: rtl/retry_scheduler_rr_pick.sv
// retry_scheduler_rr_pick: first set request at or after i_ptr, wrapping modulo 2**W.
module retry_scheduler_rr_pick #(
    parameter int W = 3
) (
    input  logic [2**W-1:0] i_req,
    input  logic [W-1:0]    i_ptr,
    output logic [W-1:0]    o_idx,
    output logic            o_valid
);
    // Scan downward so the smallest offset from i_ptr wins.
    always_comb begin
        o_idx = '0;
        o_valid = 1'b0;
        for (int k = 2**W-1; k >= 0; k--) begin
            if (i_req[i_ptr + W'(k)]) begin
                o_idx = i_ptr + W'(k);
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/retry_scheduler.sv
// retry_scheduler: allocates IDs, keeps a replay copy per ID and re-issues retried
// transactions ahead of new input, with a bounded retry budget per transaction.
module retry_scheduler
    import retry_scheduler_pkg::*;
#(
    parameter type DataType   = logic [7:0],
    parameter int  IDSize     = 3,
    parameter int  MaxRetries = 3
) (
    input logic clk_i,
    input logic rst_i,
    retry_scheduler_if.slave bus
);
    localparam int NumIds = 2**IDSize;
    localparam int CW = $clog2(MaxRetries + 1);

    typedef struct packed {
        entry_state_e state;
        logic [CW-1:0] cnt;
    } entry_t;

    entry_t            r_ent [NumIds];
    entry_t            w_ent [NumIds];
    DataType           r_mem [NumIds];
    DataType           r_data;
    logic [IDSize-1:0] r_id;
    logic [IDSize-1:0] r_ptr;
    logic [IDSize-1:0] r_fail_id;
    logic              r_valid;
    logic              r_fail;
    logic              r_spur;

    logic [NumIds-1:0] w_free;
    logic [NumIds-1:0] w_rtry;
    logic [IDSize-1:0] w_free_idx;
    logic [IDSize-1:0] w_rtry_idx;
    logic [IDSize:0]   w_outst;
    logic              w_free_any;
    logic              w_rtry_any;
    logic              w_load;
    logic              w_ready;
    logic              w_take_rtry;
    logic              w_take_new;
    logic              w_issue;
    logic              w_done_ok;
    logic              w_fail;
    logic              w_spur;

    always_comb begin
        w_free = '0;
        w_rtry = '0;
        for (int k = 0; k < NumIds; k++) begin
            w_free[k] = r_ent[k].state == FREE;
            w_rtry[k] = r_ent[k].state == RETRY;
        end
    end

    retry_scheduler_rr_pick #(.W(IDSize)) u_rtry_pick (
        .i_req  (w_rtry),
        .i_ptr  (r_ptr),
        .o_idx  (w_rtry_idx),
        .o_valid(w_rtry_any)
    );

    retry_scheduler_rr_pick #(.W(IDSize)) u_free_pick (
        .i_req  (w_free),
        .i_ptr  ('0),
        .o_idx  (w_free_idx),
        .o_valid(w_free_any)
    );

    assign w_load      = !r_valid || bus.ready_i;
    assign w_ready     = w_load && w_free_any && !w_rtry_any;
    assign w_take_rtry = w_load && w_rtry_any;
    assign w_take_new  = w_ready && bus.valid_i;
    assign w_issue     = r_valid && bus.ready_i;
    assign w_done_ok   = bus.done_valid_i && r_ent[bus.done_id_i].state == INFLIGHT;
    assign w_spur      = bus.done_valid_i && !w_done_ok;
    assign w_fail      = w_done_ok && bus.done_retry_i && r_ent[bus.done_id_i].cnt == CW'(MaxRetries);

    // Each event touches an entry in a distinct state, so the updates never collide.
    always_comb begin
        w_ent = r_ent;
        if (w_issue) w_ent[r_id].state = INFLIGHT;
        if (w_done_ok) begin
            if (bus.done_retry_i && !w_fail) begin
                w_ent[bus.done_id_i].state = RETRY;
                w_ent[bus.done_id_i].cnt = r_ent[bus.done_id_i].cnt + CW'(1);
            end else begin
                w_ent[bus.done_id_i].state = FREE;
            end
        end
        if (w_take_rtry) w_ent[w_rtry_idx].state = QUEUED;
        if (w_take_new) w_ent[w_free_idx] = '{state: QUEUED, cnt: '0};
    end

    always_comb begin
        w_outst = '0;
        for (int k = 0; k < NumIds; k++) w_outst = w_outst + (IDSize+1)'(is_busy(r_ent[k].state));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumIds; k++) r_ent[k] <= '{state: FREE, cnt: '0};
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_id      <= '0;
            r_ptr     <= '0;
            r_fail    <= 1'b0;
            r_fail_id <= '0;
            r_spur    <= 1'b0;
        end else begin
            r_ent  <= w_ent;
            r_fail <= w_fail;
            r_spur <= w_spur;
            if (w_fail) r_fail_id <= bus.done_id_i;
            if (w_take_rtry) begin
                r_data  <= r_mem[w_rtry_idx];
                r_id    <= w_rtry_idx;
                r_ptr   <= w_rtry_idx + 1'b1;
                r_valid <= 1'b1;
            end else if (w_take_new) begin
                r_data  <= bus.data_i;
                r_id    <= w_free_idx;
                r_valid <= 1'b1;
            end else if (bus.ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_take_new) r_mem[w_free_idx] <= bus.data_i;
    end

    assign bus.ready_o       = w_ready;
    assign bus.data_o        = r_data;
    assign bus.id_o          = r_id;
    assign bus.valid_o       = r_valid;
    assign bus.fail_o        = r_fail;
    assign bus.fail_id_o     = r_fail_id;
    assign bus.spurious_o    = r_spur;
    assign bus.outstanding_o = w_outst;
endmodule

// File: tb/tb_retry_scheduler.sv
// tb_retry_scheduler: scoreboard bench for retry_scheduler (IDSize=3, MaxRetries=3).
module tb_retry_scheduler;
    typedef struct packed {
        logic [2:0] id;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    retry_scheduler_if #(.DataType(logic [7:0]), .IDSize(3)) bus ();

    retry_scheduler #(.DataType(logic [7:0]), .IDSize(3), .MaxRetries(3)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb [$];
    exp_t mon_e;
    logic [7:0] busy;
    int cnt [8];
    logic [7:0] mem [8];
    logic done_rdy;
    logic post_rdy;

    always @(negedge clk) begin
        if (!rst && bus.valid_o && bus.ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue: unexpected beat id=%0d data=%h", bus.id_o, bus.data_o);
            end else begin
                mon_e = sb.pop_front();
                if (bus.id_o !== mon_e.id || bus.data_o !== mon_e.d) begin
                    errors++;
                    $display("FAIL issue: got id=%0d data=%h expected id=%0d data=%h", bus.id_o, bus.data_o, mon_e.id, mon_e.d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [2:0] lowest_free();
        logic [2:0] r = 3'd0;
        for (int k = 7; k >= 0; k--) if (!busy[k]) r = 3'(k);
        return r;
    endfunction

    function automatic int nbusy();
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(busy[k]);
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.valid_i = 1'b0;
        bus.done_valid_i = 1'b0;
        bus.done_retry_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        busy = '0;
        for (int k = 0; k < 8; k++) cnt[k] = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        logic [2:0] eid;
        bit ok = 0;
        bus.data_i = d;
        bus.valid_i = 1'b1;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                ok = 1;
                eid = lowest_free();
                busy[eid] = 1'b1;
                cnt[eid] = 0;
                mem[eid] = d;
                sb.push_back({eid, d});
            end
            tick();
        end
        bus.valid_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: ready_o=%b required 1 for data %h", bus.ready_o, d);
        end
    endtask

    task automatic complete(input logic [2:0] id, input logic r, input logic spur);
        logic exp_fail = 1'b0;
        bus.done_valid_i = 1'b1;
        bus.done_id_i = id;
        bus.done_retry_i = r;
        @(negedge clk);
        done_rdy = bus.ready_o;
        if (!spur) begin
            if (!r) busy[id] = 1'b0;
            else if (cnt[id] < 3) begin
                cnt[id]++;
                sb.push_back({id, mem[id]});
            end else begin
                busy[id] = 1'b0;
                exp_fail = 1'b1;
            end
        end
        tick();
        bus.done_valid_i = 1'b0;
        bus.done_retry_i = 1'b0;
        @(negedge clk);
        post_rdy = bus.ready_o;
        checks++;
        if (bus.fail_o !== exp_fail) begin
            errors++;
            $display("FAIL fail_pulse id=%0d: fail_o=%b required %b", id, bus.fail_o, exp_fail);
        end
        if (exp_fail) begin
            checks++;
            if (bus.fail_id_o !== id) begin
                errors++;
                $display("FAIL fail_id: fail_id_o=%0d required %0d", bus.fail_id_o, id);
            end
        end
        checks++;
        if (bus.spurious_o !== spur) begin
            errors++;
            $display("FAIL spurious id=%0d: spurious_o=%b required %b", id, bus.spurious_o, spur);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.fail_o !== 1'b0 || bus.spurious_o !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: fail_o=%b spurious_o=%b required 0 0", bus.fail_o, bus.spurious_o);
        end
        tick();
        tick();
    endtask

    task automatic drain();
        bit ok = 0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && !bus.valid_o;
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain: %0d beats still expected, valid_o=%b required 0 pending", sb.size(), bus.valid_o);
        end
    endtask

    task automatic test_reset();
        bus.ready_i = 1'b1;
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.fail_o !== 1'b0 || bus.spurious_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b fail=%b spur=%b required 0 0 0", bus.valid_o, bus.fail_o, bus.spurious_o);
        end
        checks++;
        if (bus.outstanding_o !== 4'd0 || bus.data_o !== 8'h00 || bus.id_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_regs: outst=%0d data=%h id=%0d required 0 00 0", bus.outstanding_o, bus.data_o, bus.id_o);
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_o=%b required 1", bus.ready_o);
        end
        tick();
    endtask

    task automatic test_stream();
        int peak = 0;
        logic [2:0] aid [8];
        do_reset();
        bus.ready_i = 1'b1;
        for (int t = 0; t < 14; t++) begin
            bus.valid_i = (t < 8);
            bus.data_i = 8'h10 + 8'(t);
            bus.done_valid_i = (t >= 4 && t < 12);
            bus.done_retry_i = 1'b0;
            if (t >= 4 && t < 12) bus.done_id_i = aid[t-4];
            @(negedge clk);
            checks++;
            if (bus.outstanding_o !== 4'(nbusy())) begin
                errors++;
                $display("FAIL stream_outstanding t=%0d: %0d required %0d", t, bus.outstanding_o, nbusy());
            end
            if (int'(bus.outstanding_o) > peak) peak = int'(bus.outstanding_o);
            checks++;
            if (bus.fail_o !== 1'b0 || bus.spurious_o !== 1'b0) begin
                errors++;
                $display("FAIL stream_flags t=%0d: fail=%b spur=%b required 0 0", t, bus.fail_o, bus.spurious_o);
            end
            if (t < 8) begin
                checks++;
                if (bus.ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready t=%0d: ready_o=%b required 1", t, bus.ready_o);
                end
                aid[t] = lowest_free();
                busy[aid[t]] = 1'b1;
                cnt[aid[t]] = 0;
                mem[aid[t]] = bus.data_i;
                sb.push_back({aid[t], bus.data_i});
            end
            if (t >= 4 && t < 12) busy[aid[t-4]] = 1'b0;
            tick();
        end
        bus.valid_i = 1'b0;
        bus.done_valid_i = 1'b0;
        drain();
        checks++;
        if (peak !== 4) begin
            errors++;
            $display("FAIL stream_peak: outstanding peak %0d required 4", peak);
        end
    endtask

    task automatic test_full();
        do_reset();
        bus.ready_i = 1'b1;
        for (int k = 0; k < 8; k++) send(8'h20 + 8'(k));
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: ready_o=%b required 0", bus.ready_o);
        end
        tick();
        drain();
        complete(3'd5, 1'b0, 1'b0);
        checks++;
        if (done_rdy !== 1'b0 || post_rdy !== 1'b1) begin
            errors++;
            $display("FAIL free_timing: ready_o same=%b next=%b required 0 1", done_rdy, post_rdy);
        end
        send(8'h30);
        drain();
    endtask

    task automatic test_retry_priority();
        logic [2:0] eid;
        do_reset();
        bus.ready_i = 1'b1;
        send(8'hA3);
        send(8'h11);
        send(8'hA5);
        send(8'h12);
        drain();
        bus.data_i = 8'h77;
        bus.done_valid_i = 1'b1;
        bus.done_id_i = 3'd2;
        bus.done_retry_i = 1'b1;
        @(negedge clk);
        cnt[2]++;
        sb.push_back({3'd2, mem[2]});
        tick();
        bus.done_valid_i = 1'b0;
        bus.done_retry_i = 1'b0;
        bus.valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL retry_blocks_ready: ready_o=%b required 0", bus.ready_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.id_o !== 3'd2 || bus.data_o !== 8'hA5) begin
            errors++;
            $display("FAIL retry_first: valid=%b id=%0d data=%h required 1 2 a5", bus.valid_o, bus.id_o, bus.data_o);
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL retry_then_ready: ready_o=%b required 1", bus.ready_o);
        end else begin
            eid = lowest_free();
            busy[eid] = 1'b1;
            cnt[eid] = 0;
            mem[eid] = 8'h77;
            sb.push_back({eid, 8'h77});
        end
        tick();
        bus.valid_i = 1'b0;
        drain();
    endtask

    task automatic test_budget();
        do_reset();
        bus.ready_i = 1'b1;
        send(8'h40);
        send(8'h41);
        drain();
        for (int k = 0; k < 4; k++) complete(3'd1, 1'b1, 1'b0);
        drain();
        @(negedge clk);
        checks++;
        if (bus.outstanding_o !== 4'd1) begin
            errors++;
            $display("FAIL budget_outstanding: %0d required 1", bus.outstanding_o);
        end
        tick();
        send(8'h55);
        drain();
    endtask

    task automatic test_spurious();
        do_reset();
        bus.ready_i = 1'b0;
        complete(3'd6, 1'b0, 1'b1);
        checks++;
        if (bus.outstanding_o !== 4'd0 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL spur_free_state: outst=%0d valid=%b required 0 0", bus.outstanding_o, bus.valid_o);
        end
        send(8'h60);
        complete(3'd0, 1'b0, 1'b1);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.id_o !== 3'd0 || bus.data_o !== 8'h60 || bus.outstanding_o !== 4'd1) begin
            errors++;
            $display("FAIL spur_queued_state: valid=%b id=%0d data=%h outst=%0d required 1 0 60 1", bus.valid_o, bus.id_o, bus.data_o, bus.outstanding_o);
        end
        bus.ready_i = 1'b1;
        drain();
    endtask

    task automatic test_stall_reset();
        do_reset();
        bus.ready_i = 1'b0;
        send(8'h81);
        bus.data_i = 8'h82;
        bus.valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.valid_o !== 1'b1 || bus.id_o !== 3'd0 || bus.data_o !== 8'h81 || bus.ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall c=%0d: valid=%b id=%0d data=%h ready=%b required 1 0 81 0", c, bus.valid_o, bus.id_o, bus.data_o, bus.ready_o);
            end
            tick();
        end
        rst = 1'b1;
        bus.done_valid_i = 1'b1;
        bus.done_id_i = 3'd0;
        bus.done_retry_i = 1'b1;
        @(negedge clk);
        sb.delete();
        busy = '0;
        for (int k = 0; k < 8; k++) cnt[k] = 0;
        tick();
        rst = 1'b0;
        bus.done_valid_i = 1'b0;
        bus.done_retry_i = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.outstanding_o !== 4'd0 || bus.spurious_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b outst=%0d spur=%b required 0 0 0", bus.valid_o, bus.outstanding_o, bus.spurious_o);
        end
        tick();
        bus.ready_i = 1'b1;
        send(8'h99);
        drain();
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i = 8'h00;
        bus.ready_i = 1'b0;
        bus.done_valid_i = 1'b0;
        bus.done_id_i = 3'd0;
        bus.done_retry_i = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_retry_priority();
        test_budget();
        test_spurious();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/retry_scheduler.md
Name: retry_scheduler

Overview:
- Sequencing controller in front of the time-DMR retry pipeline: accepts new transactions, allocates IDs, keeps a replay copy per ID, and re-issues transactions flagged for retry.
- Pending retries are arbitrated ahead of new input, and each transaction gets a bounded retry budget.
- Sits where the retry source would sit: upstream handshake in, ID-tagged stream out to the DMR start stage, completion feedback from the retry sink.

Parameters:
- DataType, logic [7:0], payload type stored and replayed.
- IDSize, 3, ID width; NumIds = 2**IDSize table entries.
- MaxRetries, 3, retries allowed per transaction before it is declared failed; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  DataType  upstream payload.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  DataType  payload to DMR start.
- id_o  out  IDSize  ID of the issued transaction.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- done_valid_i  in  1  completion report valid; single-cycle, no backpressure.
- done_id_i  in  IDSize  ID being completed.
- done_retry_i  in  1  completion requests a retry.
- fail_o  out  1  one-cycle pulse: retry budget exhausted.
- fail_id_o  out  IDSize  ID of the failed transaction; valid while fail_o is high.
- spurious_o  out  1  one-cycle pulse: completion for an ID not INFLIGHT.
- outstanding_o  out  IDSize+1  count of non-FREE entries.

Behaviour:
- Reset is synchronous and active-high, one clock: all entries FREE, all retry counters 0, output register empty.
- Reset values: valid_o=0, fail_o=0, spurious_o=0, outstanding_o=0, data_o/id_o=0.
- Reset mid-operation discards all state; completions arriving in the reset cycle are ignored.
- Per-entry state: FREE, QUEUED (in output register), INFLIGHT (issued, awaiting completion), RETRY (awaiting re-issue). Each entry also holds a stored payload and a retry counter of clog2(MaxRetries+1) bits.
- Output register: holds one beat. data_o, id_o and valid_o are driven from flops and stay stable until ready_i. It can load when empty or when it is draining (valid_o && ready_i) in the same cycle.
- Selection each cycle when the output register can load:
  - (1) Any entry in RETRY: pick round-robin, starting after the last retried ID; load the stored payload; entry goes RETRY->QUEUED.
  - (2) Otherwise, if valid_i && ready_o: allocate the lowest-index FREE entry, store data_i, clear its counter; entry goes FREE->QUEUED.
- ready_o = output register can load && at least one FREE entry && no RETRY entry.
  - ready_o is combinational from state and ready_i; it does not depend on valid_i.
- Latency: 1 cycle from upstream handshake to valid_o. Full throughput of 1 beat/cycle while IDs are available.
- Downstream handshake (valid_o && ready_i): the issued entry goes QUEUED->INFLIGHT.
- Completion (done_valid_i), for an entry that is INFLIGHT:
  - done_retry_i=0: entry goes to FREE.
  - done_retry_i=1 and counter < MaxRetries: counter increments, entry goes to RETRY.
  - done_retry_i=1 and counter == MaxRetries: entry goes to FREE; fail_o and fail_id_o are registered and asserted for 1 cycle.
- Completion for an entry in any other state: no state change; spurious_o is pulsed for 1 cycle.
- Same-cycle events:
  - An entry freed by a completion is not allocatable until the next cycle.
  - An entry set to RETRY becomes eligible for selection the next cycle.
  - An issue handshake and a completion on different IDs are both applied.
- Full: all NumIds entries non-FREE -> ready_o=0. Retries still drain.
- outstanding_o updates one cycle after the causing event and saturates at NumIds.
- The round-robin pointer wraps from NumIds-1 to 0.

Decomposition:
- Shared package retry_pkg: entry-state enum (FREE, QUEUED, INFLIGHT, RETRY) and an entry struct (state, counter).
- Sub-module rr_pick: round-robin first-one finder over an NumIds-bit request vector, with a pointer input, returning index and valid. It is reused for FREE allocation with the pointer tied to 0.

Test Plan:
- Reset, then 8 beats 0x10..0x17 with ready_i=1 and each completed 4 cycles after issue with retry=0 -> ids 0..7, data unchanged, outstanding_o peaks at 4, no fail_o or spurious_o.
- IDSize=3, fill 8 IDs with no completions -> ready_o=0 after the 8th handshake. Complete ID 5 -> ready_o=1 the cycle after; the next beat gets id 5.
- Complete ID 2 (data 0xA5) with retry=1 while valid_i is held -> next issue is id 2 / 0xA5 before any new data; ready_o=0 during that cycle.
- Retry ID 1 four times with MaxRetries=3 -> three re-issues of the same payload; on the 4th, fail_o=1 and fail_id_o=1 for 1 cycle; ID 1 is FREE afterwards.
- Completion for ID 6 while FREE, and for ID 0 while QUEUED (ready_i=0) -> spurious_o pulses each time; state and outputs are unchanged.
- Hold ready_i=0 for 5 cycles with valid_o=1 -> data_o/id_o stay stable. Assert rst_i mid-stream -> the next cycle has valid_o=0, outstanding_o=0, and the first new beat gets id 0.
